// File: rtl/msk_cipher_out_serializer.sv
// Serializes one masked 128-bit ciphertext from the AES core into four 32-bit masked words.
// Shares are only moved, never combined; the buffer shifts in zeros as words leave.
module msk_cipher_out_serializer #(
    parameter int d = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_cipher_valid,
    input  logic [128*d-1:0]    core_sh_ciphertext,
    output logic                core_out_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*d-1:0]     out_sh_data,
    output logic                out_last,
    output logic                busy
);

    localparam int WordW = 32 * d;
    localparam int BufW  = 128 * d;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    logic              r_state;
    logic [BufW-1:0]   r_buffer;
    logic [1:0]        r_cnt;

    logic              w_capture;
    logic              w_beat;

    assign core_out_ready = !rst && (r_state == ST_IDLE);
    assign out_valid      = (r_state == ST_SEND);
    assign busy           = (r_state == ST_SEND);
    assign out_last       = out_valid && (r_cnt == 2'd3);
    // Gate the data bus so held shares are never visible outside a valid beat.
    assign out_sh_data    = out_valid ? r_buffer[0 +: WordW] : '0;

    assign w_capture = core_cipher_valid && core_out_ready;
    assign w_beat    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_buffer <= '0;
            r_cnt    <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_buffer <= core_sh_ciphertext;
                        r_cnt    <= 2'd0;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_beat) begin
                        // Zero fill from the top clears each share once it has been sent.
                        r_buffer <= {{WordW{1'b0}}, r_buffer[BufW-1:WordW]};
                        r_cnt    <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_cipher_out_serializer.sv
// Scoreboard bench for msk_cipher_out_serializer (d=2): stimulus pushes expected beats,
// a negedge monitor pops and compares them and checks gating and stall stability.
module tb_msk_cipher_out_serializer;

    localparam int D = 2;

    logic              clk;
    logic              rst;
    logic              core_cipher_valid;
    logic [128*D-1:0]  core_sh_ciphertext;
    logic              core_out_ready;
    logic              out_valid;
    logic              out_ready;
    logic [32*D-1:0]   out_sh_data;
    logic              out_last;
    logic              busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int beats       = 0;

    logic [64:0] expQ [$];

    logic        prevStall = 1'b0;
    logic        prevRst   = 1'b1;
    logic [63:0] prevData  = '0;
    logic        prevLast  = 1'b0;

    msk_cipher_out_serializer #(.d(D)) dut (
        .clk                (clk),
        .rst                (rst),
        .core_cipher_valid  (core_cipher_valid),
        .core_sh_ciphertext (core_sh_ciphertext),
        .core_out_ready     (core_out_ready),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_sh_data        (out_sh_data),
        .out_last           (out_last),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Share 0 on even bit positions, share 1 on odd ones.
    function automatic logic [63:0] packWord(input logic [31:0] s0, input logic [31:0] s1);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            r[2*j]   = s0[j];
            r[2*j+1] = s1[j];
        end
        return r;
    endfunction

    function automatic logic [255:0] packBlock(input logic [127:0] s0, input logic [127:0] s1);
        logic [255:0] r;
        for (int k = 0; k < 4; k++) r[64*k +: 64] = packWord(s0[32*k +: 32], s1[32*k +: 32]);
        return r;
    endfunction

    task automatic pushExpected(input logic [127:0] s0, input logic [127:0] s1);
        for (int k = 0; k < 4; k++) expQ.push_back({(k == 3), packWord(s0[32*k +: 32], s1[32*k +: 32])});
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            logic [64:0] e;
            beats++;
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected_beat: got data %0h, expected no beat", out_sh_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("beat_data", {192'b0, out_sh_data}, {192'b0, e[63:0]});
                checkOutput("beat_last", {255'b0, out_last}, {255'b0, e[64]});
            end
        end
        if (!out_valid) checkOutput("gated_data", {192'b0, out_sh_data}, '0);
        if (prevStall && !prevRst) begin
            checkOutput("stall_valid", {255'b0, out_valid}, {255'b0, 1'b1});
            checkOutput("stall_data", {192'b0, out_sh_data}, {192'b0, prevData});
            checkOutput("stall_last", {255'b0, out_last}, {255'b0, prevLast});
        end
        prevStall = out_valid && !out_ready;
        prevRst   = rst;
        prevData  = out_sh_data;
        prevLast  = out_last;
    end

    // Present a block, wait (bounded) for the capture edge, then remove valid.
    task automatic applyStimulus(input logic [127:0] s0, input logic [127:0] s1);
        int n;
        core_cipher_valid  = 1'b1;
        core_sh_ciphertext = packBlock(s0, s1);
        pushExpected(s0, s1);
        n = 0;
        @(negedge clk);
        while (!core_out_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!core_out_ready) checkOutput("capture_timeout", 256'd0, 256'd1);
        @(posedge clk);
        #1;
        core_cipher_valid  = 1'b0;
        core_sh_ciphertext = {8{$urandom}};
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || expQ.size() != 0) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (busy || expQ.size() != 0) checkOutput({name, "_timeout"}, {255'b0, busy}, '0);
        checkOutput({name, "_buffer_clear"}, dut.r_buffer, '0);
    endtask

    task automatic stepCheck(input string name, input logic expValid, input logic expCor,
                             input logic expLast);
        @(negedge clk);
        checkOutput({name, "_valid"}, {255'b0, out_valid}, {255'b0, expValid});
        checkOutput({name, "_core_ready"}, {255'b0, core_out_ready}, {255'b0, expCor});
        checkOutput({name, "_last"}, {255'b0, out_last}, {255'b0, expLast});
    endtask

    localparam logic [127:0] S0A = 128'h196a0b32_dc118597_02dc09fb_3925841d;
    localparam logic [127:0] S1A = {4{32'hA5A5A5A5}};
    localparam logic [127:0] S0B = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] S1B = 128'h12345678_9abcdef0_0fedcba9_87654321;
    localparam logic [127:0] S0C = 128'hdeadbeef_cafef00d_13579bdf_2468ace0;
    localparam logic [127:0] S1C = 128'h5a5a5a5a_c3c3c3c3_ffffffff_00000000;

    initial begin
        int b0;
        rst                = 1'b1;
        core_cipher_valid  = 1'b0;
        core_sh_ciphertext = '0;
        out_ready          = 1'b1;

        // Reset then idle
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_core_ready", {255'b0, core_out_ready}, '0);
            checkOutput("rst_valid", {255'b0, out_valid}, '0);
            checkOutput("rst_busy", {255'b0, busy}, '0);
            checkOutput("rst_data", {192'b0, out_sh_data}, '0);
        end
        @(posedge clk); #1; rst = 1'b0;
        stepCheck("idle", 1'b0, 1'b1, 1'b0);
        checkOutput("idle_busy", {255'b0, busy}, '0);
        checkOutput("idle_data", {192'b0, out_sh_data}, '0);

        // Single block without stalls: four consecutive beats after capture
        @(posedge clk); #1;
        applyStimulus(S0A, S1A);
        stepCheck("single_b0", 1'b1, 1'b0, 1'b0);
        stepCheck("single_b1", 1'b1, 1'b0, 1'b0);
        stepCheck("single_b2", 1'b1, 1'b0, 1'b0);
        stepCheck("single_b3", 1'b1, 1'b0, 1'b1);
        stepCheck("single_end", 1'b0, 1'b1, 1'b0);
        checkOutput("single_buffer", dut.r_buffer, '0);
        checkOutput("single_queue", {224'b0, expQ.size()}, '0);

        // Backpressure during word 1
        @(posedge clk); #1;
        b0 = beats;
        applyStimulus(S0B, S1B);
        @(negedge clk);
        @(posedge clk); #1; out_ready = 1'b0;
        repeat (3) begin
            stepCheck("stall", 1'b1, 1'b0, 1'b0);
            checkOutput("stall_word1", {192'b0, out_sh_data}, {192'b0, packWord(S0B[63:32], S1B[63:32])});
        end
        @(posedge clk); #1; out_ready = 1'b1;
        waitIdle("stall");
        checkOutput("stall_beats", {224'b0, beats - b0}, 256'd4);

        // Back-to-back: valid held, second capture one cycle after last beat
        @(posedge clk); #1;
        core_cipher_valid  = 1'b1;
        core_sh_ciphertext = packBlock(S0A, S1A);
        pushExpected(S0A, S1A);
        pushExpected(S0C, S1C);
        stepCheck("b2b_cap0", 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        core_sh_ciphertext = packBlock(S0C, S1C);
        stepCheck("b2b_a0", 1'b1, 1'b0, 1'b0);
        stepCheck("b2b_a1", 1'b1, 1'b0, 1'b0);
        stepCheck("b2b_a2", 1'b1, 1'b0, 1'b0);
        stepCheck("b2b_a3", 1'b1, 1'b0, 1'b1);
        stepCheck("b2b_cap1", 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        core_cipher_valid = 1'b0;
        stepCheck("b2b_c0", 1'b1, 1'b0, 1'b0);
        waitIdle("b2b");

        // Valid toggled while busy must be ignored
        @(posedge clk); #1;
        applyStimulus(S0B, S1B);
        for (int i = 0; i < 4; i++) begin
            core_cipher_valid  = ~core_cipher_valid;
            core_sh_ciphertext = packBlock(S0C, S1C);
            stepCheck("ignore", 1'b1, 1'b0, (i == 3));
            @(posedge clk); #1;
        end
        core_cipher_valid = 1'b0;
        stepCheck("ignore_end", 1'b0, 1'b1, 1'b0);
        waitIdle("ignore");

        // Reset after the first beat drops the rest of the block
        @(posedge clk); #1;
        applyStimulus(S0C, S1C);
        @(negedge clk);
        @(posedge clk); #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_core_ready", {255'b0, core_out_ready}, '0);
        expQ.delete();
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_valid", {255'b0, out_valid}, '0);
        checkOutput("mid_rst_busy", {255'b0, busy}, '0);
        checkOutput("mid_rst_data", {192'b0, out_sh_data}, '0);
        checkOutput("mid_rst_buffer", dut.r_buffer, '0);
        checkOutput("mid_rst_core_ready_after", {255'b0, core_out_ready}, {255'b0, 1'b1});
        @(posedge clk); #1;
        applyStimulus(S0A, S1A);
        waitIdle("after_rst");

        // Reset and valid together: no capture
        @(posedge clk); #1;
        rst                = 1'b1;
        core_cipher_valid  = 1'b1;
        core_sh_ciphertext = packBlock(S0B, S1B);
        @(negedge clk);
        checkOutput("rst_valid_core_ready", {255'b0, core_out_ready}, '0);
        @(posedge clk); #1;
        rst               = 1'b0;
        core_cipher_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid_no_capture", {255'b0, out_valid}, '0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/msk_cipher_out_serializer.md
Name: msk_cipher_out_serializer

Overview:
- Downstream stage of the 32-bit masked AES core.
- Accepts one masked 128-bit ciphertext (bit-compact sharing, 128*d bits) through the core's cipher_valid/out_ready handshake.
- Streams it out as four 32-bit masked words (32*d bits each) over a valid/ready interface with a last flag.
- Clears held shares after they are sent, so no stale sensitive data stays in the buffer.

Parameters:
- d, 2, number of shares. Each logical bit j occupies bits [j*d +: d] of a bus.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- core_cipher_valid  input  1  ciphertext valid from core
- core_sh_ciphertext  input  128*d  masked ciphertext from core (bit-compact)
- core_out_ready  output  1  drives core out_ready; transfer when core_cipher_valid && core_out_ready
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts word
- out_sh_data  output  32*d  masked 32-bit word; logical bits 32k..32k+31 = core_sh_ciphertext[32*d*k +: 32*d]
- out_last  output  1  high with word k=3
- busy  output  1  high while a ciphertext is held

Behaviour:
- One clock, one domain. Reset is synchronous, active-high, and has priority over all events.
- Reset values:
  - state=IDLE, buffer=0, cnt=0
  - core_out_ready=0 while rst high
  - out_valid=0, out_sh_data=0, out_last=0, busy=0
- FSM states:
  - IDLE:
    - core_out_ready=1 (combinational from state, and only when rst low); out_valid=0; busy=0.
    - On core_cipher_valid && core_out_ready: buffer <= core_sh_ciphertext, cnt <= 0, go SEND.
  - SEND:
    - core_out_ready=0; out_valid=1; busy=1.
    - out_sh_data = buffer[0 +: 32*d]; out_last = (cnt==3).
    - On out_valid && out_ready:
      - buffer <= buffer >> 32*d with zero fill in the top 32*d bits.
      - cnt <= cnt+1.
      - If cnt==3: go IDLE; the buffer is all-zero at this point.
- Word order: word 0 (logical bits 0..31) first, word 3 (bits 96..127) last.
- Output gating: out_sh_data is forced to 0 whenever out_valid=0 (mux on out_valid). Internal shares never appear on the output outside a valid beat.
- Stall: if out_ready=0 in SEND, out_sh_data, out_last and cnt hold stable and out_valid stays 1. Validity may not be withdrawn.
- Latency:
  - Capture cycle, then first word valid in the next cycle.
  - Minimum 4 cycles SEND plus 1 cycle IDLE per ciphertext, i.e. 5 cycles per block at full throughput.
  - No back-to-back capture during the final beat; this 1-cycle bubble is intentional.
- core_cipher_valid in SEND is ignored. The core holds the ciphertext until core_out_ready is seen.
- core_sh_ciphertext is only sampled on the transfer cycle. Its value at other times is don't-care.
- cnt is 2 bits and never wraps in SEND; the transition out occurs exactly at cnt==3 plus a handshake.
- Reset mid-SEND: buffer is zeroed, outputs go to reset values next cycle, and remaining words are dropped. The core is not re-handshaked; the ciphertext is lost.
- rst and core_cipher_valid high together: no capture; core_out_ready=0 in that cycle.
- No arithmetic on shares: the block only moves shares and never combines them.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, core_cipher_valid=0.
  - Required: core_out_ready=0 during rst and 1 afterwards; out_valid=0, out_sh_data=0, busy=0 throughout.
- Single block, no stalls (d=2):
  - Stimulus: core_sh_ciphertext where logical word k has share0=32'h3925841d/02dc09fb/dc118597/196a0b32 (k=0..3) and share1=32'hA5A5A5A5; out_ready=1.
  - Required: four beats on consecutive cycles, starting 1 cycle after capture, with the matching share pairs in word order; out_last only on beat 4; core_out_ready=0 for those 4 cycles; buffer==0 afterwards.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles during beat 2.
  - Required: out_sh_data/out_last stable and out_valid=1 during the stall; beat 2 completes when out_ready=1; total 4 beats.
- Back-to-back blocks:
  - Stimulus: core_cipher_valid held high with a second ciphertext.
  - Required: the second capture occurs exactly 1 cycle after the last beat of the first block; 5-cycle period.
- Reset mid-send:
  - Stimulus: assert rst after beat 1.
  - Required: next cycle out_valid=0, out_sh_data=0, busy=0, buffer=0; after rst drops, core_out_ready=1 and the next ciphertext is sent from word 0.
- Ignored valid while busy:
  - Stimulus: toggle core_cipher_valid in SEND.
  - Required: core_out_ready stays 0 and the buffer is unaffected.
